// File: rtl/memory_access_sequencer.sv
// Byte-serial sequencer between the address handler and a byte-wide synchronous RAM.
// Loads assemble up to four bytes into ReadData; stores split WriteData into bytes.
module memory_access_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] FAULT_ADDR = 10'h3FF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    write,
  input  logic [1:0]              size,
  input  logic [4*ADDR_WIDTH-1:0] Address,
  input  logic [31:0]             WriteData,
  input  logic [7:0]              mem_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    mem_we,
  output logic [31:0]             ReadData,
  output logic                    busy,
  output logic                    done,
  output logic                    fault
);

  typedef enum logic [1:0] {StIdle, StXfer, StReadTail, StDone} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [1:0]              last_q, last_d;
  logic                    write_q, write_d;
  logic [4*ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]              mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    fault_q, fault_d;
  logic                    cap_q, cap_d;
  logic [1:0]              cap_idx_q, cap_idx_d;

  logic [ADDR_WIDTH-1:0]   in_lane [4];
  logic [ADDR_WIDTH-1:0]   lane_q  [4];
  logic                    bad_req;
  logic [1:0]              nxt_idx;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_lane[k] = Address[k*ADDR_WIDTH +: ADDR_WIDTH];
      lane_q[k]  = addr_q[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Only lanes that the access will actually use can raise a fault.
  always_comb begin
    case (size)
      2'd0:    bad_req = (in_lane[0] == FAULT_ADDR);
      2'd1:    bad_req = (in_lane[0] == FAULT_ADDR) || (in_lane[1] == FAULT_ADDR);
      2'd2:    bad_req = (in_lane[0] == FAULT_ADDR) || (in_lane[1] == FAULT_ADDR) ||
                         (in_lane[2] == FAULT_ADDR) || (in_lane[3] == FAULT_ADDR);
      default: bad_req = 1'b1;
    endcase
  end

  assign nxt_idx = idx_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    cap_d       = 1'b0;
    cap_idx_d   = cap_idx_q;

    // RAM data returns one cycle after the address was issued.
    if (cap_q) begin
      rdata_d[{cap_idx_q, 3'b000} +: 8] = mem_rdata;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          write_d = write;
          addr_d  = Address;
          wdata_d = WriteData;
          last_d  = (size == 2'd0) ? 2'd0 : (size == 2'd1) ? 2'd1 : 2'd3;
          idx_d   = 2'd0;
          if (bad_req) begin
            state_d = StDone;
            fault_d = 1'b1;
          end else begin
            state_d    = StXfer;
            mem_addr_d = in_lane[0];
            if (write) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = WriteData[7:0];
            end else begin
              rdata_d = '0;
            end
          end
        end
      end
      StXfer: begin
        cap_d     = !write_q;
        cap_idx_d = idx_q;
        if (idx_q == last_q) begin
          state_d = write_q ? StDone : StReadTail;
        end else begin
          idx_d      = nxt_idx;
          mem_addr_d = lane_q[nxt_idx];
          if (write_q) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = wdata_q[{nxt_idx, 3'b000} +: 8];
          end
        end
      end
      StReadTail: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        fault_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      last_q      <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      cap_q       <= 1'b0;
      cap_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      cap_q       <= cap_d;
      cap_idx_q   <= cap_idx_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign ReadData  = rdata_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign fault     = fault_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Bench for memory_access_sequencer: behavioural byte RAM, expectation queues, per-scenario tasks.
module tb_memory_access_sequencer;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          write;
  logic [1:0]    size;
  logic [4*AW-1:0] Address;
  logic [31:0]   WriteData;
  logic [7:0]    mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [31:0]   ReadData;
  logic          busy;
  logic          done;
  logic          fault;

  memory_access_sequencer #(.ADDR_WIDTH(AW), .FAULT_ADDR(10'h3FF)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .write     (write),
    .size      (size),
    .Address   (Address),
    .WriteData (WriteData),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .ReadData  (ReadData),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [1024];
  always @(posedge clock) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we === 1'b1) ram[mem_addr] = mem_wdata;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {logic [AW-1:0] a; logic [7:0] d;} wr_t;
  typedef struct {int lat; logic flt; logic [31:0] rd;} res_t;
  typedef struct {logic w; logic [1:0] sz; logic [4*AW-1:0] ad; logic [31:0] wd;
                  int lat; logic flt; logic [31:0] rd;} txn_t;

  wr_t  obs_wr [$];
  wr_t  exp_wr [$];
  res_t exp_q  [$];
  int   checks   = 0;
  int   failures = 0;
  int   t0;

  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      wr_t o;
      o.a = mem_addr;
      o.d = mem_wdata;
      obs_wr.push_back(o);
    end
  end

  function automatic logic [4*AW-1:0] pk(input logic [AW-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Drives one request and pushes its expected outcome; t0 marks the acceptance edge.
  task automatic issue(input txn_t t, input bit hold);
    res_t r;
    int   n;
    @(negedge clock);
    write = t.w; size = t.sz; Address = t.ad; WriteData = t.wd; start = 1'b1;
    obs_wr.delete();
    exp_wr.delete();
    n = (t.sz == 2'd0) ? 1 : (t.sz == 2'd1) ? 2 : 4;
    if (t.w && !t.flt) begin
      for (int k = 0; k < n; k++) begin
        wr_t e;
        e.a = t.ad[k*AW +: AW];
        e.d = t.wd[k*8 +: 8];
        exp_wr.push_back(e);
      end
    end
    r.lat = t.lat; r.flt = t.flt; r.rd = t.rd;
    exp_q.push_back(r);
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        ok  = 1'b1;
        lat = cyc - t0 + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_we, busy, done, fault} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {mem_we, busy, done, fault});
    end
    checks++;
    if (ReadData !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=00000000", ReadData);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mem got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_store_load();
    txn_t tbl [7];
    res_t r;
    int   lat;
    bit   ok;
    tbl[0] = '{1'b1, 2'd2, pk(10'h43, 10'h42, 10'h41, 10'h40), 32'hA1B2C3D4, 5, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 2'd2, pk(10'h43, 10'h42, 10'h41, 10'h40), 32'h0, 6, 1'b0, 32'hA1B2C3D4};
    tbl[2] = '{1'b1, 2'd2, pk(10'h100, 10'h101, 10'h102, 10'h103), 32'hFFFFFFFF, 5, 1'b0,
               32'hA1B2C3D4};
    tbl[3] = '{1'b0, 2'd2, pk(10'h100, 10'h101, 10'h102, 10'h103), 32'h0, 6, 1'b0, 32'hFFFFFFFF};
    tbl[4] = '{1'b0, 2'd0, pk(10'h024, 10'h0, 10'h0, 10'h0), 32'h0, 3, 1'b0, 32'h0000007E};
    tbl[5] = '{1'b0, 2'd1, pk(10'h40, 10'h41, 10'h0, 10'h0), 32'h0, 4, 1'b0, 32'h0000B2A1};
    tbl[6] = '{1'b0, 2'd0, pk(10'h43, 10'h1, 10'h2, 10'h3), 32'h0, 3, 1'b0, 32'h000000D4};
    for (int i = 0; i < 7; i++) begin
      issue(tbl[i], 1'b0);
      wait_done(lat, ok);
      r = exp_q.pop_front();
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL sl%0d_done_timeout got=none exp=done", i);
        continue;
      end
      checks++;
      if (lat !== r.lat) begin
        failures++;
        $display("FAIL sl%0d_latency got=%0d exp=%0d", i, lat, r.lat);
      end
      checks++;
      if (fault !== r.flt) begin
        failures++;
        $display("FAIL sl%0d_fault got=%b exp=%b", i, fault, r.flt);
      end
      checks++;
      if (ReadData !== r.rd) begin
        failures++;
        $display("FAIL sl%0d_rdata got=%h exp=%h", i, ReadData, r.rd);
      end
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin
        failures++;
        $display("FAIL sl%0d_wr_count got=%0d exp=%0d", i, obs_wr.size(), exp_wr.size());
      end else begin
        foreach (exp_wr[k]) begin
          checks++;
          if (obs_wr[k].a !== exp_wr[k].a || obs_wr[k].d !== exp_wr[k].d) begin
            failures++;
            $display("FAIL sl%0d_wr%0d got=%h@%h exp=%h@%h", i, k, obs_wr[k].d, obs_wr[k].a,
                     exp_wr[k].d, exp_wr[k].a);
          end
        end
      end
    end
  endtask

  task automatic test_fault();
    txn_t          tbl [6];
    res_t          r;
    int            lat;
    bit            ok;
    logic [AW-1:0] ma;
    tbl[0] = '{1'b0, 2'd0, pk(10'h3FF, 10'h0, 10'h0, 10'h0), 32'h0, 1, 1'b1, 32'h000000D4};
    tbl[1] = '{1'b1, 2'd3, pk(10'h1, 10'h2, 10'h3, 10'h4), 32'h12345678, 1, 1'b1, 32'h000000D4};
    tbl[2] = '{1'b0, 2'd2, pk(10'h40, 10'h41, 10'h42, 10'h3FF), 32'h0, 1, 1'b1, 32'h000000D4};
    tbl[3] = '{1'b0, 2'd1, pk(10'h40, 10'h3FF, 10'h0, 10'h0), 32'h0, 1, 1'b1, 32'h000000D4};
    tbl[4] = '{1'b0, 2'd0, pk(10'h42, 10'h3FF, 10'h3FF, 10'h3FF), 32'h0, 3, 1'b0, 32'h000000C3};
    tbl[5] = '{1'b1, 2'd0, pk(10'h3FE, 10'h3FF, 10'h0, 10'h0), 32'h99, 2, 1'b0, 32'h000000C3};
    for (int i = 0; i < 6; i++) begin
      ma = mem_addr;
      issue(tbl[i], 1'b0);
      wait_done(lat, ok);
      r = exp_q.pop_front();
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL ft%0d_done_timeout got=none exp=done", i);
        continue;
      end
      checks++;
      if (lat !== r.lat || fault !== r.flt) begin
        failures++;
        $display("FAIL ft%0d_lat_fault got=%0d/%b exp=%0d/%b", i, lat, fault, r.lat, r.flt);
      end
      checks++;
      if (ReadData !== r.rd) begin
        failures++;
        $display("FAIL ft%0d_rdata got=%h exp=%h", i, ReadData, r.rd);
      end
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin
        failures++;
        $display("FAIL ft%0d_wr_count got=%0d exp=%0d", i, obs_wr.size(), exp_wr.size());
      end else begin
        foreach (exp_wr[k]) begin
          checks++;
          if (obs_wr[k].a !== exp_wr[k].a || obs_wr[k].d !== exp_wr[k].d) begin
            failures++;
            $display("FAIL ft%0d_wr%0d got=%h@%h exp=%h@%h", i, k, obs_wr[k].d, obs_wr[k].a,
                     exp_wr[k].d, exp_wr[k].a);
          end
        end
      end
      if (r.flt) begin
        checks++;
        if (mem_addr !== ma) begin
          failures++;
          $display("FAIL ft%0d_addr_idle got=%h exp=%h", i, mem_addr, ma);
        end
      end
    end
  endtask

  task automatic test_start_held();
    txn_t t;
    res_t r;
    int   lat;
    bit   ok;
    t = '{1'b1, 2'd1, pk(10'h60, 10'h61, 10'h0, 10'h0), 32'h0000BEEF, 3, 1'b0, 32'h000000C3};
    issue(t, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      wait_done(lat, ok);
      r = exp_q.pop_front();
      checks++;
      if (!ok || lat !== r.lat) begin
        failures++;
        $display("FAIL held%0d_latency got=%0d exp=%0d", pass, lat, r.lat);
      end
      checks++;
      if (obs_wr.size() != 2) begin
        failures++;
        $display("FAIL held%0d_wr_count got=%0d exp=2", pass, obs_wr.size());
      end else begin
        checks++;
        if (obs_wr[0].d !== 8'hEF || obs_wr[1].d !== 8'hBE || obs_wr[1].a !== 10'h61) begin
          failures++;
          $display("FAIL held%0d_wr_data got=%h,%h@%h exp=ef,be@061", pass, obs_wr[0].d,
                   obs_wr[1].d, obs_wr[1].a);
        end
      end
      if (pass == 0) begin
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL held_done_cycle_start got=busy%b exp=busy0", busy);
        end
        obs_wr.delete();
        r.lat = 3; r.flt = 1'b0; r.rd = 32'h000000C3;
        exp_q.push_back(r);
        @(posedge clock);
        #1;
        start = 1'b0;
        t0 = cyc;
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL held_next_accept got=busy%b exp=busy1", busy);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    txn_t t;
    res_t r;
    int   lat;
    bit   ok;
    t = '{1'b1, 2'd2, pk(10'h200, 10'h201, 10'h202, 10'h203), 32'h11223344, 5, 1'b0, 32'h0};
    issue(t, 1'b0);
    void'(exp_q.pop_front());
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_we, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL areset_drop got=%b exp=000", {mem_we, busy, done});
    end
    checks++;
    if (ReadData !== 32'h0) begin
      failures++;
      $display("FAIL areset_rdata got=%h exp=00000000", ReadData);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    t = '{1'b1, 2'd0, pk(10'h210, 10'h0, 10'h0, 10'h0), 32'h0000005A, 2, 1'b0, 32'h0};
    issue(t, 1'b0);
    wait_done(lat, ok);
    r = exp_q.pop_front();
    checks++;
    if (!ok || lat !== r.lat || fault !== r.flt) begin
      failures++;
      $display("FAIL areset_new_store got=%0d/%b exp=%0d/%b", lat, fault, r.lat, r.flt);
    end
    checks++;
    if (obs_wr.size() != 1) begin
      failures++;
      $display("FAIL areset_wr_count got=%0d exp=1", obs_wr.size());
    end
    @(negedge clock);
    checks++;
    if (ram[10'h210] !== 8'h5A || ram[10'h200] !== 8'h44) begin
      failures++;
      $display("FAIL areset_ram_written got=%h,%h exp=5a,44", ram[10'h210], ram[10'h200]);
    end
    checks++;
    if ({ram[10'h201], ram[10'h202], ram[10'h203]} !== 24'h0) begin
      failures++;
      $display("FAIL areset_ram_aborted got=%h exp=000000",
               {ram[10'h201], ram[10'h202], ram[10'h203]});
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h024] = 8'h7E;
    reset = 1'b1; start = 1'b0; write = 1'b0; size = 2'd0; Address = '0; WriteData = '0;
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_store_load();
    test_fault();
    test_start_held();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
